// File: rtl/frame_buffer_write_arbiter_if.sv
// frame_buffer_write_arbiter_if: drawer request channels and frame_buffer write port
interface frame_buffer_write_arbiter_if #(
    parameter int NUM_CHANNELS = 3,
    parameter int ADDR_WIDTH = 19,
    parameter int PIXEL_WIDTH = 1
);
    logic pause;
    logic [NUM_CHANNELS-1:0] req_valid;
    logic [NUM_CHANNELS-1:0] req_ready;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] req_data;
    logic write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [PIXEL_WIDTH-1:0] write_data;
    logic busy;
    logic oob_error;
    modport master (
        output pause, req_valid, req_addr, req_data,
        input req_ready, write_enable, write_addr, write_data, busy, oob_error
    );
    modport slave (
        input pause, req_valid, req_addr, req_data,
        output req_ready, write_enable, write_addr, write_data, busy, oob_error
    );
endinterface

// File: rtl/frame_buffer_write_arbiter.sv
// frame_buffer_write_arbiter: merges N drawer pixel streams onto one registered frame_buffer write port
module frame_buffer_write_arbiter #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int NUM_CHANNELS = 3,
    parameter int PIXEL_WIDTH = 1,
    parameter int ARB_MODE = 0,
    parameter int BURST_LIMIT = 16
) (
    input logic clk,
    input logic rst,
    frame_buffer_write_arbiter_if.slave bus
);
    localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int ADDR_WIDTH = $clog2(PIXELS_COUNT);
    localparam int CH_WIDTH = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam bit RR = ARB_MODE == 1 && NUM_CHANNELS > 1;

    logic [CH_WIDTH-1:0] ptr_q, ptr_d, last_q, last_d, gnt_idx;
    logic [7:0] cnt_q, cnt_d, cnt_base;
    logic [CH_WIDTH:0] idx;
    logic found, accept, in_range;
    logic [NUM_CHANNELS-1:0] gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [PIXEL_WIDTH-1:0] sel_data;
    logic write_enable_q, write_enable_d, oob_error_q, oob_error_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [PIXEL_WIDTH-1:0] write_data_q, write_data_d;

    // Grant search: from the round-robin pointer, or from channel 0 in fixed mode.
    always_comb begin
        found = 1'b0;
        gnt_idx = '0;
        idx = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = (RR ? {1'b0, ptr_q} : '0) + (CH_WIDTH+1)'(k);
            idx = idx >= (CH_WIDTH+1)'(NUM_CHANNELS) ? idx - (CH_WIDTH+1)'(NUM_CHANNELS) : idx;
            if (!found && bus.req_valid[idx[CH_WIDTH-1:0]]) begin
                found = 1'b1;
                gnt_idx = idx[CH_WIDTH-1:0];
            end
        end
        accept = found & ~bus.pause & ~rst;
        gnt = '0;
        gnt[gnt_idx] = accept;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (gnt_idx == CH_WIDTH'(k)) begin
                sel_addr = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = bus.req_data[k*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
        in_range = {1'b0, sel_addr} < (ADDR_WIDTH+1)'(PIXELS_COUNT);
    end

    // A new grantee starts from count 0, so BURST_LIMIT=1 rotates after every beat.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        last_d = last_q;
        cnt_base = gnt_idx == last_q ? cnt_q : 8'd0;
        if (RR && accept) begin
            last_d = gnt_idx;
            cnt_d = cnt_base < 8'(BURST_LIMIT-1) ? cnt_base + 8'd1 : 8'd0;
            ptr_d = cnt_base < 8'(BURST_LIMIT-1) ? gnt_idx :
                    gnt_idx == CH_WIDTH'(NUM_CHANNELS-1) ? '0 : gnt_idx + CH_WIDTH'(1);
        end else if (RR && !bus.pause && !bus.req_valid[last_q]) begin
            cnt_d = 8'd0;
        end
    end

    always_comb begin
        write_enable_d = accept & in_range;
        write_addr_d = accept ? sel_addr : write_addr_q;
        write_data_d = accept ? sel_data : write_data_q;
        oob_error_d = oob_error_q | (accept & ~in_range);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            last_q <= '0;
            write_enable_q <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            oob_error_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            write_enable_q <= write_enable_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            oob_error_q <= oob_error_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.write_enable = write_enable_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.oob_error = oob_error_q;
    assign bus.busy = |bus.req_valid | write_enable_q;
endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// tb_frame_buffer_write_arbiter: directed vectors on a fixed-priority and a round-robin (burst 4) instance
module tb_frame_buffer_write_arbiter;
    localparam int AW = 19;

    typedef struct {
        logic [2:0] valid;
        logic pause;
        logic [AW-1:0] a0, a1, a2;
        logic [2:0] rdy;
        logic we;
        logic [AW-1:0] wa;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;
    int writes;
    vec_t vecs[13];
    int rr_order[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    logic [2:0] pause_rdy[7] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b100};
    logic pause_seq[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    frame_buffer_write_arbiter_if #(.NUM_CHANNELS(3), .ADDR_WIDTH(AW), .PIXEL_WIDTH(1)) fx();
    frame_buffer_write_arbiter_if #(.NUM_CHANNELS(3), .ADDR_WIDTH(AW), .PIXEL_WIDTH(1)) rr();

    frame_buffer_write_arbiter #(.ARB_MODE(0), .BURST_LIMIT(16)) dut_fx (.clk(clk), .rst(rst), .bus(fx));
    frame_buffer_write_arbiter #(.ARB_MODE(1), .BURST_LIMIT(4)) dut_rr (.clk(clk), .rst(rst), .bus(rr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fx(input logic [2:0] v, input logic p, input logic [AW-1:0] a0, a1, a2);
        fx.req_valid = v;
        fx.pause = p;
        fx.req_addr = {a2, a1, a0};
        fx.req_data = {a2[0], a1[0], a0[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'b101, 1'b0, 19'd10, 19'd0, 19'd900, 3'b001, 1'b0, 19'd0};
        vecs[1]  = '{3'b101, 1'b0, 19'd11, 19'd0, 19'd900, 3'b001, 1'b1, 19'd10};
        vecs[2]  = '{3'b101, 1'b0, 19'd12, 19'd0, 19'd900, 3'b001, 1'b1, 19'd11};
        vecs[3]  = '{3'b101, 1'b0, 19'd13, 19'd0, 19'd900, 3'b001, 1'b1, 19'd12};
        vecs[4]  = '{3'b101, 1'b0, 19'd14, 19'd0, 19'd900, 3'b001, 1'b1, 19'd13};
        vecs[5]  = '{3'b110, 1'b0, 19'd0, 19'd500, 19'd900, 3'b010, 1'b1, 19'd14};
        vecs[6]  = '{3'b100, 1'b0, 19'd0, 19'd500, 19'd900, 3'b100, 1'b1, 19'd500};
        vecs[7]  = '{3'b111, 1'b1, 19'd0, 19'd500, 19'd900, 3'b000, 1'b1, 19'd900};
        vecs[8]  = '{3'b000, 1'b0, 19'd0, 19'd0, 19'd0, 3'b000, 1'b0, 19'd900};
        vecs[9]  = '{3'b010, 1'b0, 19'd0, 19'd307199, 19'd900, 3'b010, 1'b0, 19'd900};
        vecs[10] = '{3'b000, 1'b0, 19'd0, 19'd0, 19'd0, 3'b000, 1'b1, 19'd307199};
        vecs[11] = '{3'b011, 1'b0, 19'd5, 19'd6, 19'd0, 3'b001, 1'b0, 19'd307199};
        vecs[12] = '{3'b000, 1'b0, 19'd0, 19'd0, 19'd0, 3'b000, 1'b1, 19'd5};

        drive_fx(3'b111, 1'b0, 19'd1, 19'd2, 19'd3);
        rr.req_valid = 3'b000;
        rr.pause = 1'b0;
        rr.req_addr = {19'd3, 19'd2, 19'd1};
        rr.req_data = 3'b000;
        #2;
        chk("reset_ready", 32'(fx.req_ready), 32'd0);
        chk("reset_we", 32'(fx.write_enable), 32'd0);
        chk("reset_waddr", 32'(fx.write_addr), 32'd0);
        chk("reset_wdata", 32'(fx.write_data), 32'd0);
        chk("reset_oob", 32'(fx.oob_error), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive_fx(vecs[i].valid, vecs[i].pause, vecs[i].a0, vecs[i].a1, vecs[i].a2);
            #2;
            chk($sformatf("fx%0d_ready", i), 32'(fx.req_ready), 32'(vecs[i].rdy));
            chk($sformatf("fx%0d_we", i), 32'(fx.write_enable), 32'(vecs[i].we));
            chk($sformatf("fx%0d_waddr", i), 32'(fx.write_addr), 32'(vecs[i].wa));
            chk($sformatf("fx%0d_wdata", i), 32'(fx.write_data), 32'(vecs[i].wa[0]));
            chk($sformatf("fx%0d_busy", i), 32'(fx.busy), 32'(|vecs[i].valid | vecs[i].we));
            tick();
        end

        writes = 0;
        for (int i = 0; i < 12; i++) begin
            rr.req_valid = 3'b111;
            #2;
            chk($sformatf("rr_all%0d_ready", i), 32'(rr.req_ready), 32'(3'b001 << rr_order[i]));
            tick();
            writes += int'(rr.write_enable);
        end
        chk("rr_all_writes", 32'(writes), 32'd12);
        chk("rr_all_last_addr", 32'(rr.write_addr), 32'd3);

        writes = 0;
        for (int i = 0; i < 20; i++) begin
            rr.req_valid = 3'b010;
            #2;
            chk($sformatf("rr_lone%0d_ready", i), 32'(rr.req_ready), 32'b010);
            tick();
            writes += int'(rr.write_enable);
        end
        chk("rr_lone_writes", 32'(writes), 32'd20);
        rr.req_valid = 3'b000;
        drive_fx(3'b000, 1'b0, 19'd0, 19'd0, 19'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            rr.req_valid = 3'b110;
            rr.pause = pause_seq[i];
            #2;
            chk($sformatf("rr_pause%0d_ready", i), 32'(rr.req_ready), 32'(pause_rdy[i]));
            tick();
        end
        rr.req_valid = 3'b000;
        rr.pause = 1'b0;

        drive_fx(3'b001, 1'b0, 19'd307200, 19'd0, 19'd0);
        fx.req_data = 3'b001;
        #2;
        chk("oob_ready", 32'(fx.req_ready), 32'b001);
        tick();
        drive_fx(3'b000, 1'b0, 19'd0, 19'd0, 19'd0);
        #2;
        chk("oob_we", 32'(fx.write_enable), 32'd0);
        chk("oob_flag", 32'(fx.oob_error), 32'd1);
        tick();
        tick();
        tick();
        chk("oob_sticky", 32'(fx.oob_error), 32'd1);

        drive_fx(3'b001, 1'b0, 19'd50, 19'd0, 19'd0);
        tick();
        chk("arst_pre_we", 32'(fx.write_enable), 32'd1);
        chk("arst_pre_waddr", 32'(fx.write_addr), 32'd50);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(fx.write_enable), 32'd0);
        chk("arst_waddr", 32'(fx.write_addr), 32'd0);
        chk("arst_oob", 32'(fx.oob_error), 32'd0);
        chk("arst_ready", 32'(fx.req_ready), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_release_ready", 32'(fx.req_ready), 32'b001);
        tick();
        chk("arst_release_we", 32'(fx.write_enable), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
